// File: rtl/sa_ram_rws_param.sv
// ============================================================================
// Module   : sa_ram_rws_param
// Purpose  : Parametrised single-clock RAM model with one write port and one
//            read port. Read data is registered and held between reads, and
//            a read-valid flag marks the cycles that carry fresh data.
//            WR_FIRST selects what a read returns when it hits the address
//            being written in the same cycle. CLEAR_ON_RESET zero-fills the
//            whole array after reset.
// Optional : `define SA_RAM_OUT_REG_EN adds one output register stage, which
//            makes the read latency 2.
// Ports    : clk           - clock, rising edge
//            rst           - synchronous active-high reset
//            ra / re       - read address / read enable
//            dout          - read data (held between reads)
//            dout_vld      - dout was refreshed by a read
//            wa / we / di  - write address / write enable / write data
//            init_busy     - zero-clear sequence in progress
//            pwrbus_ram_pd - power-down bus (no functional effect)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sa_ram_rws_param #(
  parameter int WIDTH          = 3,
  parameter int DEPTH          = 256,
  parameter int AW             = 8,
  parameter int WR_FIRST       = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter bit FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  output logic             init_busy,
  input  logic [31:0]      pwrbus_ram_pd
);

  // One extra bit so that DEPTH == 2**AW is representable.
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_init_busy;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_vld;
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  logic             w_ra_ok;
  logic             w_wa_ok;
  logic             w_collide;
  logic [WIDTH-1:0] w_rd_word;
  logic             w_unused_sink;

  // Power-down bus and the compatibility parameter are accepted but unused.
  assign w_unused_sink = ^{pwrbus_ram_pd, FORCE_CONTENTION_ASSERTION_RESET_ACTIVE};

  assign w_ra_ok   = ({1'b0, ra} < c_depth);
  assign w_wa_ok   = ({1'b0, wa} < c_depth);
  assign w_collide = we && (wa == ra);

  // Out-of-range reads return zero. On a same-address collision the new
  // data is forwarded only in write-first mode; otherwise the array still
  // holds the old word at this edge.
  always_comb begin
    w_rd_word = '0;
    if (w_ra_ok) begin
      if ((WR_FIRST != 0) && w_collide) begin
        w_rd_word = di;
      end else begin
        w_rd_word = r_mem[ra];
      end
    end
  end

  // Control FSM: clear sequencing, read capture and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_cnt       <= '0;
      r_init_busy <= (CLEAR_ON_RESET != 0);
      r_rd_data   <= '0;
      r_rd_vld    <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rd_vld <= 1'b0;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state     <= ST_READY;
            r_init_busy <= 1'b0;
          end
        end
        ST_READY: begin
          r_rd_vld <= re;
          if (re) begin
            r_rd_data <= w_rd_word;
          end
        end
        default: begin
          r_state <= ST_READY;
        end
      endcase
    end
  end

  // Storage array. Not reset directly; the clear sequence zero-fills it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else if (we && w_wa_ok) begin
        r_mem[wa] <= di;
      end
    end
  end

  assign init_busy = r_init_busy;

`ifdef SA_RAM_OUT_REG_EN
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_vld;

  // Extra pipeline stage: advances only when the first stage holds new data,
  // otherwise keeps the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      r_out_vld <= r_rd_vld;
      if (r_rd_vld) begin
        r_out_data <= r_rd_data;
      end
    end
  end

  assign dout     = r_out_data;
  assign dout_vld = r_out_vld;
`else
  assign dout     = r_rd_data;
  assign dout_vld = r_rd_vld;
`endif

endmodule

`default_nettype wire
